// File: rtl/seq_mult_unit.sv
// Unsigned shift-add multiplier: WIDTH RUN cycles, then a one-cycle done pulse (start edge + WIDTH + 1).
// No backpressure: mult_ld is ignored while busy; result holds until the next done.
module seq_mult_unit #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_mult_ld,
  input  logic [WIDTH-1:0]   i_op_a,
  input  logic [WIDTH-1:0]   i_op_b,
  output logic               o_busy,
  output logic               o_mult_done,
  output logic [2*WIDTH-1:0] o_product,
  output logic [WIDTH-1:0]   o_product_lo,
  output logic               o_mult_ovf,
  output logic               o_mult_zero
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_a;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_product;
  logic [PW-1:0]   w_acc_sum;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;
  logic            r_zero;
  logic            w_start;
  logic            w_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_last      = 1'b0;
    o_busy      = 1'b0;
    o_mult_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_mult_ld) begin
          w_start     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_mult_done = 1'b1;
        // A held mult_ld restarts here, giving back-to-back operations.
        if (i_mult_ld) begin
          w_start     = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The partial sum never exceeds 2*WIDTH bits, so no carry is lost.
  assign w_acc_sum = r_b[0] ? (r_acc + r_a) : r_acc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b1;
    end else if (w_start) begin
      r_a   <= {{WIDTH{1'b0}}, i_op_a};
      r_b   <= i_op_b;
      r_acc <= '0;
      r_cnt <= CW'(WIDTH);
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_sum;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt - 1'b1;
      if (w_last) begin
        r_product <= w_acc_sum;
        r_ovf     <= |w_acc_sum[PW-1:WIDTH];
        r_zero    <= (w_acc_sum == '0);
      end
    end
  end

  assign o_product    = r_product;
  assign o_product_lo = r_product[WIDTH-1:0];
  assign o_mult_ovf   = r_ovf;
  assign o_mult_zero  = r_zero;

endmodule
